ssram_rr_arbiter: RTL and testbench

SSRAM_RR_ARBITER -- requirements
Module: ssram_rr_arbiter

---
 rtl/ssram_rr_arbiter_pkg.sv | 17 +
 rtl/ssram_tag_fifo.sv | 57 +++++
 rtl/ssram_rr_arbiter.sv | 154 +++++++++++++++
 tb/tb_ssram_rr_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssram_rr_arbiter_pkg.sv
// Shared types and defaults for the SSRAM round-robin arbiter and its tag FIFO.
package ssram_rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  localparam int NPORT_DEF = 3;
  localparam int MAXRD_DEF = 8;

  // Index width that stays legal for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ssram_tag_fifo.sv
// In-order FIFO of requester indices for reads awaiting avm_readdatavalid.
module ssram_tag_fifo
  import ssram_rr_arbiter_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic [idx_w(DEPTH):0]      count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = idx_w(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == FULL_CNT);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push && !full;
  // A pop against an empty FIFO is an error upstream; count must not underflow.
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ssram_rr_arbiter.sv
// Round-robin arbiter of NPORT requesters onto one Avalon-MM master, with
// in-order read-data routing back to the requester that issued each read.
//
// state | meaning
// IDLE  | no command on the bus; pick next eligible port after last_grant
// ISSUE | command presented on avm_*, held until waitrequest drops
module ssram_rr_arbiter
  import ssram_rr_arbiter_pkg::*;
#(
  parameter int NPORT = NPORT_DEF,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int MAXRD = MAXRD_DEF
) (
  input  logic                afi_phy_clk,
  input  logic                afi_phy_rst_n,
  input  logic [NPORT-1:0]    port_req,
  input  logic [NPORT-1:0]    port_we,
  input  logic [NPORT*AW-1:0] port_addr,
  input  logic [NPORT*DW-1:0] port_wdata,
  output logic [NPORT-1:0]    port_ack,
  output logic [DW-1:0]       port_rdata,
  output logic [NPORT-1:0]    port_rvalid,
  output logic [AW-1:0]       avm_address,
  output logic [DW-1:0]       avm_writedata,
  output logic                avm_write,
  output logic                avm_read,
  input  logic                avm_waitrequest,
  input  logic [DW-1:0]       avm_readdata,
  input  logic                avm_readdatavalid,
  output logic                rd_err
);

  localparam int GW = idx_w(NPORT);
  localparam int CW = idx_w(MAXRD) + 1;
  localparam logic [GW-1:0] LAST_PORT = GW'(NPORT - 1);
  localparam logic [CW-1:0] MAXRD_CNT = CW'(MAXRD);

  arb_state_t     state;
  arb_state_t     state_nxt;
  logic [GW-1:0]  last_grant;
  logic [GW-1:0]  sel;
  logic [GW-1:0]  pick;
  logic [GW-1:0]  cand;
  logic           found;
  logic           load;
  logic           accept;
  logic [NPORT-1:0] eligible;
  logic [AW-1:0]  addr_arr  [NPORT];
  logic [DW-1:0]  wdata_arr [NPORT];

  logic           tag_push;
  logic [GW-1:0]  tag_out;
  logic [CW-1:0]  tag_count;
  logic           tag_empty;
  logic           tag_full;

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      addr_arr[i]  = port_addr[i*AW +: AW];
      wdata_arr[i] = port_wdata[i*DW +: DW];
    end
  end

  // Writes never consume a tag, so a full tag FIFO only blocks reads.
  assign eligible = port_req & (port_we | {NPORT{tag_count < MAXRD_CNT}});

  always_comb begin
    found = 1'b0;
    pick  = last_grant;
    cand  = '0;
    for (int k = 1; k <= NPORT; k++) begin
      cand = GW'((int'(last_grant) + k) % NPORT);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge afi_phy_clk or negedge afi_phy_rst_n) begin
    if (!afi_phy_rst_n) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          load      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!avm_waitrequest) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign port_ack = accept ? (NPORT'(1) << sel) : '0;

  always_ff @(posedge afi_phy_clk or negedge afi_phy_rst_n) begin
    if (!afi_phy_rst_n) begin
      avm_address   <= '0;
      avm_writedata <= '0;
      avm_write     <= 1'b0;
      avm_read      <= 1'b0;
      sel           <= '0;
      last_grant    <= LAST_PORT;
      rd_err        <= 1'b0;
    end else begin
      if (load) begin
        avm_address   <= addr_arr[pick];
        avm_writedata <= wdata_arr[pick];
        avm_write     <= port_we[pick];
        avm_read      <= ~port_we[pick];
        sel           <= pick;
      end else if (accept) begin
        avm_write  <= 1'b0;
        avm_read   <= 1'b0;
        last_grant <= sel;
      end
      if (avm_readdatavalid && tag_empty) rd_err <= 1'b1;
    end
  end

  assign tag_push = accept && avm_read && !tag_full;

  ssram_tag_fifo #(
    .W     (GW),
    .DEPTH (MAXRD)
  ) u_tag_fifo (
    .clk       (afi_phy_clk),
    .rst_n     (afi_phy_rst_n),
    .push      (tag_push),
    .push_data (sel),
    .pop       (avm_readdatavalid),
    .pop_data  (tag_out),
    .count     (tag_count),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  assign port_rdata  = avm_readdata;
  assign port_rvalid = (avm_readdatavalid && !tag_empty) ? (NPORT'(1) << tag_out) : '0;

endmodule

// File: tb/tb_ssram_rr_arbiter.sv
// Directed bench for ssram_rr_arbiter: arbitration order, waitrequest hold,
// read-tag limits, read-data routing, rd_err and reset behaviour.
module tb_ssram_rr_arbiter;

  localparam int NPORT = 3;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int MAXRD = 8;

  logic                afi_phy_clk = 1'b0;
  logic                afi_phy_rst_n = 1'b0;
  logic [NPORT-1:0]    port_req = '0;
  logic [NPORT-1:0]    port_we = '0;
  logic [NPORT*AW-1:0] port_addr = '0;
  logic [NPORT*DW-1:0] port_wdata = '0;
  logic [NPORT-1:0]    port_ack;
  logic [DW-1:0]       port_rdata;
  logic [NPORT-1:0]    port_rvalid;
  logic [AW-1:0]       avm_address;
  logic [DW-1:0]       avm_writedata;
  logic                avm_write;
  logic                avm_read;
  logic                avm_waitrequest = 1'b0;
  logic [DW-1:0]       avm_readdata = '0;
  logic                avm_readdatavalid = 1'b0;
  logic                rd_err;

  int n_vec  = 0;
  int n_fail = 0;

  ssram_rr_arbiter #(.NPORT(NPORT), .AW(AW), .DW(DW), .MAXRD(MAXRD)) dut (
    .afi_phy_clk       (afi_phy_clk),
    .afi_phy_rst_n     (afi_phy_rst_n),
    .port_req          (port_req),
    .port_we           (port_we),
    .port_addr         (port_addr),
    .port_wdata        (port_wdata),
    .port_ack          (port_ack),
    .port_rdata        (port_rdata),
    .port_rvalid       (port_rvalid),
    .avm_address       (avm_address),
    .avm_writedata     (avm_writedata),
    .avm_write         (avm_write),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .rd_err            (rd_err)
  );

  always #5 afi_phy_clk = ~afi_phy_clk;

  task automatic do_reset();
    @(negedge afi_phy_clk);
    afi_phy_rst_n = 1'b0;
    port_req = '0;
    port_we = '0;
    avm_readdatavalid = 1'b0;
    avm_waitrequest = 1'b0;
    repeat (2) @(negedge afi_phy_clk);
    afi_phy_rst_n = 1'b1;
  endtask

  // Single-port command; returns at the negedge after the ack with req dropped.
  task automatic issue_one(input int p, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    bit got;
    got = 1'b0;
    port_req[p] = 1'b1;
    port_we[p] = we;
    port_addr[p*AW +: AW] = a;
    port_wdata[p*DW +: DW] = d;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (port_ack[p]) got = 1'b1;
      @(negedge afi_phy_clk);
    end
    port_req[p] = 1'b0;
    n_vec++;
    if (!got) begin
      n_fail++;
      $display("FAIL issue_one port%0d: got no ack, want ack within 20 cycles", p);
    end
  endtask

  task automatic test_reset();
    do_reset();
    avm_readdatavalid = 1'b1;
    avm_waitrequest = 1'b1;
    port_req = 3'b001;
    port_we = 3'b001;
    port_addr[0 +: AW] = 32'h1234_5678;
    port_wdata[0 +: DW] = 32'h0000_CAFE;
    @(negedge afi_phy_clk);
    avm_readdatavalid = 1'b0;
    avm_waitrequest = 1'b0;
    afi_phy_rst_n = 1'b0;
    #1;
    n_vec++; if (avm_write !== 1'b0) begin n_fail++; $display("FAIL rst_write: got %b want 0", avm_write); end
    n_vec++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL rst_read: got %b want 0", avm_read); end
    n_vec++; if (avm_address !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", avm_address); end
    n_vec++; if (avm_writedata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", avm_writedata); end
    n_vec++; if (port_ack !== 3'b000) begin n_fail++; $display("FAIL rst_ack: got %b want 000", port_ack); end
    n_vec++; if (port_rvalid !== 3'b000) begin n_fail++; $display("FAIL rst_rvalid: got %b want 000", port_rvalid); end
    n_vec++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL rst_rd_err: got %b want 0", rd_err); end
    port_req = '0;
  endtask

  task automatic test_round_robin();
    logic [NPORT-1:0] exp_ack [12];
    logic [AW-1:0]    exp_addr [12];
    exp_ack  = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100,
                 3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100};
    exp_addr = '{32'h0, 32'h1000_0000, 32'h0, 32'h1000_0001, 32'h0, 32'h1000_0002,
                 32'h0, 32'h1000_0000, 32'h0, 32'h1000_0001, 32'h0, 32'h1000_0002};
    do_reset();
    port_addr = {32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    port_wdata = {32'h0000_00D2, 32'h0000_00D1, 32'h0000_00D0};
    port_we = 3'b111;
    port_req = 3'b111;
    for (int c = 0; c < 12; c++) begin
      #1;
      n_vec++;
      if (port_ack !== exp_ack[c]) begin
        n_fail++; $display("FAIL rr_ack c%0d: got %b want %b", c, port_ack, exp_ack[c]);
      end
      if (c % 2 == 1) begin
        n_vec++;
        if (avm_write !== 1'b1 || avm_address !== exp_addr[c]) begin
          n_fail++;
          $display("FAIL rr_cmd c%0d: got wr=%b addr=%h want wr=1 addr=%h",
                   c, avm_write, avm_address, exp_addr[c]);
        end
      end
      @(negedge afi_phy_clk);
    end
    port_req = '0;
  endtask

  task automatic test_waitrequest();
    do_reset();
    port_req = 3'b010;
    port_we = 3'b000;
    port_addr[AW +: AW] = 32'h0800_0010;
    avm_waitrequest = 1'b1;
    #1;
    n_vec++; if (avm_read !== 1'b0 || port_ack !== 3'b000) begin
      n_fail++; $display("FAIL wr_c0: got rd=%b ack=%b want rd=0 ack=000", avm_read, port_ack); end
    @(negedge afi_phy_clk);
    for (int c = 1; c < 4; c++) begin
      #1;
      n_vec++;
      if (avm_read !== 1'b1 || avm_address !== 32'h0800_0010 || port_ack !== 3'b000) begin
        n_fail++;
        $display("FAIL wr_hold c%0d: got rd=%b addr=%h ack=%b want rd=1 addr=08000010 ack=000",
                 c, avm_read, avm_address, port_ack);
      end
      @(negedge afi_phy_clk);
    end
    avm_waitrequest = 1'b0;
    #1;
    n_vec++;
    if (avm_read !== 1'b1 || avm_address !== 32'h0800_0010 || port_ack !== 3'b010) begin
      n_fail++;
      $display("FAIL wr_accept: got rd=%b addr=%h ack=%b want rd=1 addr=08000010 ack=010",
               avm_read, avm_address, port_ack);
    end
    @(negedge afi_phy_clk);
    port_req = '0;
    #1;
    n_vec++; if (avm_read !== 1'b0 || port_ack !== 3'b000) begin
      n_fail++; $display("FAIL wr_after: got rd=%b ack=%b want rd=0 ack=000", avm_read, port_ack); end
  endtask

  task automatic test_fifo_full();
    int acks;
    do_reset();
    port_we = 3'b000;
    port_addr[2*AW +: AW] = 32'h2000_0000;
    port_req = 3'b100;
    acks = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (port_ack[2]) acks++;
      @(negedge afi_phy_clk);
    end
    n_vec++; if (acks !== 8) begin n_fail++; $display("FAIL ff_eight_reads: got %0d acks want 8", acks); end
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++;
      if (avm_read !== 1'b0 || port_ack !== 3'b000) begin
        n_fail++; $display("FAIL ff_withheld c%0d: got rd=%b ack=%b want rd=0 ack=000", c, avm_read, port_ack);
      end
      @(negedge afi_phy_clk);
    end
    port_req[0] = 1'b1;
    port_we[0] = 1'b1;
    port_addr[0 +: AW] = 32'h3000_0000;
    @(negedge afi_phy_clk);
    #1;
    n_vec++;
    if (port_ack !== 3'b001 || avm_write !== 1'b1 || avm_address !== 32'h3000_0000) begin
      n_fail++;
      $display("FAIL ff_write: got ack=%b wr=%b addr=%h want ack=001 wr=1 addr=30000000",
               port_ack, avm_write, avm_address);
    end
    @(negedge afi_phy_clk);
    port_req[0] = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h0000_0055;
    #1;
    n_vec++;
    if (port_rvalid !== 3'b100 || port_rdata !== 32'h0000_0055) begin
      n_fail++; $display("FAIL ff_pop: got rvalid=%b rdata=%h want 100 00000055", port_rvalid, port_rdata);
    end
    @(negedge afi_phy_clk);
    avm_readdatavalid = 1'b0;
    @(negedge afi_phy_clk);
    #1;
    n_vec++;
    if (avm_read !== 1'b1 || port_ack !== 3'b100) begin
      n_fail++; $display("FAIL ff_ninth: got rd=%b ack=%b want rd=1 ack=100", avm_read, port_ack);
    end
    @(negedge afi_phy_clk);
    port_req = '0;
  endtask

  task automatic test_rdata_routing();
    logic [DW-1:0]    rd_tab [3];
    logic [NPORT-1:0] rv_tab [3];
    rd_tab = '{32'h0000_000A, 32'h0000_000B, 32'h0000_000C};
    rv_tab = '{3'b001, 3'b100, 3'b010};
    do_reset();
    issue_one(0, 1'b0, 32'h4000_0000, 32'h0);
    issue_one(2, 1'b0, 32'h4000_0020, 32'h0);
    issue_one(1, 1'b0, 32'h4000_0010, 32'h0);
    for (int i = 0; i < 3; i++) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = rd_tab[i];
      #1;
      n_vec++;
      if (port_rvalid !== rv_tab[i] || port_rdata !== rd_tab[i]) begin
        n_fail++;
        $display("FAIL route%0d: got rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                 i, port_rvalid, port_rdata, rv_tab[i], rd_tab[i]);
      end
      @(negedge afi_phy_clk);
    end
    avm_readdatavalid = 1'b0;
    #1;
    n_vec++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL route_no_err: got %b want 0", rd_err); end
  endtask

  task automatic test_rd_err();
    do_reset();
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h0000_0077;
    #1;
    n_vec++; if (port_rvalid !== 3'b000) begin n_fail++; $display("FAIL err_rvalid: got %b want 000", port_rvalid); end
    @(negedge afi_phy_clk);
    avm_readdatavalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky c%0d: got %b want 1", c, rd_err); end
      @(negedge afi_phy_clk);
    end
    issue_one(1, 1'b0, 32'h5000_0000, 32'h0);
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h0000_0099;
    #1;
    n_vec++;
    if (port_rvalid !== 3'b010 || port_rdata !== 32'h0000_0099 || rd_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_then_read: got rvalid=%b rdata=%h err=%b want 010 00000099 1",
               port_rvalid, port_rdata, rd_err);
    end
    @(negedge afi_phy_clk);
    avm_readdatavalid = 1'b0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    issue_one(0, 1'b0, 32'h6000_0000, 32'h0);
    issue_one(1, 1'b0, 32'h6000_0010, 32'h0);
    issue_one(2, 1'b0, 32'h6000_0020, 32'h0);
    avm_waitrequest = 1'b1;
    port_we = 3'b000;
    port_req = 3'b001;
    @(negedge afi_phy_clk);
    #1;
    n_vec++; if (avm_read !== 1'b1) begin n_fail++; $display("FAIL mid_issue: got rd=%b want 1", avm_read); end
    afi_phy_rst_n = 1'b0;
    avm_waitrequest = 1'b0;
    #1;
    n_vec++;
    if (avm_read !== 1'b0 || port_ack !== 3'b000) begin
      n_fail++; $display("FAIL mid_rst: got rd=%b ack=%b want rd=0 ack=000", avm_read, port_ack);
    end
    @(negedge afi_phy_clk);
    port_req = '0;
    afi_phy_rst_n = 1'b1;
    @(negedge afi_phy_clk);
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h0000_00EE;
    #1;
    n_vec++; if (port_rvalid !== 3'b000) begin n_fail++; $display("FAIL mid_stale_rvalid: got %b want 000", port_rvalid); end
    @(negedge afi_phy_clk);
    avm_readdatavalid = 1'b0;
    #1;
    n_vec++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL mid_stale_err: got %b want 1", rd_err); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_waitrequest();
    test_fifo_full();
    test_rdata_routing();
    test_rd_err();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
